// File: rtl/show_scheduler.sv
// Show scheduler: walks a programmable playlist, launches one pattern generator at a time
// and forwards its lights to the drivers, with a blackout gap between patterns.
module show_scheduler #(
    parameter int NUM_PAT     = 4,
    parameter int PL_DEPTH    = 8,
    parameter int CLKS_PER_MS = 50000,
    parameter int GAP_MS      = 500,
    parameter int TIMEOUT_MS  = 600000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic                         pl_we,
    input  logic [2:0]                   pl_addr,
    input  logic [$clog2(NUM_PAT)-1:0]   pl_data,
    input  logic [3:0]                   pl_len,
    output logic [NUM_PAT-1:0]           pat_go,
    input  logic [NUM_PAT-1:0]           pat_finished,
    input  logic [8*NUM_PAT-1:0]         pat_lights,
    output logic [7:0]                   lights,
    output logic [$clog2(NUM_PAT)-1:0]   cur_pat,
    output logic                         busy,
    output logic                         timeout_err
);
    localparam int PW = $clog2(NUM_PAT);
    localparam int TW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_MS - 1);
    localparam logic [19:0]   GAP_END   = 20'(GAP_MS);
    localparam logic [19:0]   TO_END    = 20'(TIMEOUT_MS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    logic [1:0]    state, state_d;
    logic [2:0]    idx, idx_d, idx_adv;
    logic [PW-1:0] entry [PL_DEPTH];
    logic [TW-1:0] tick_cnt;
    logic [19:0]   ms_cnt;
    logic          ms_tick;
    logic [7:0]    sel_lights, lights_d;
    logic          sel_fin;
    logic [3:0]    eff_len, idx_inc;
    logic          to_set, cnt_clr;

    assign ms_tick = (tick_cnt == TICK_LAST);
    assign busy    = (state != S_IDLE);

    // Indices with no attached generator select dark lights and never finish.
    always_comb begin
        sel_lights = '0;
        sel_fin    = 1'b0;
        for (int k = 0; k < NUM_PAT; k++) begin
            if (cur_pat == PW'(k)) begin
                sel_lights = pat_lights[8*k +: 8];
                sel_fin    = pat_finished[k];
            end
        end
    end

    // Go is decoded purely from registers so it cannot glitch with inputs.
    always_comb begin
        pat_go = '0;
        for (int k = 0; k < NUM_PAT; k++) begin
            pat_go[k] = (state == S_LAUNCH) && (entry[idx] == PW'(k));
        end
    end

    always_comb begin
        eff_len = (pl_len > 4'(PL_DEPTH)) ? 4'(PL_DEPTH) : pl_len;
        idx_inc = {1'b0, idx} + 4'd1;
        idx_adv = (idx_inc >= eff_len) ? 3'd0 : idx_inc[2:0];
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        lights_d = '0;
        to_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run && pl_len != 4'd0) state_d = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_PLAY;
            S_PLAY: begin
                if (!run) begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                end else if (sel_fin) begin
                    state_d = S_GAP;
                    idx_d   = idx_adv;
                end else if (ms_cnt == TO_END) begin
                    state_d = S_GAP;
                    idx_d   = idx_adv;
                    to_set  = 1'b1;
                end else begin
                    lights_d = sel_lights;
                end
            end
            S_GAP: begin
                if (ms_cnt == GAP_END) begin
                    if (run && pl_len != 4'd0) begin
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        cnt_clr = (state_d != state) && (state_d == S_LAUNCH || state_d == S_GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= 3'd0;
            lights      <= '0;
            cur_pat     <= '0;
            timeout_err <= 1'b0;
            tick_cnt    <= '0;
            ms_cnt      <= '0;
            for (int i = 0; i < PL_DEPTH; i++) entry[i] <= '0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            lights <= lights_d;
            if (to_set) timeout_err <= 1'b1;
            if (state == S_LAUNCH) cur_pat <= entry[idx];
            if (pl_we) entry[pl_addr] <= pl_data;
            if (cnt_clr) begin
                tick_cnt <= '0;
                ms_cnt   <= '0;
            end else begin
                tick_cnt <= ms_tick ? '0 : tick_cnt + 1'b1;
                if (ms_tick) ms_cnt <= ms_cnt + 20'd1;
            end
        end
    end
endmodule

// File: tb/tb_show_scheduler.sv
// Bench for show_scheduler: directed playlist scenarios; every launch pulse is
// checked against a queue of expected pat_go values by an independent monitor.
module tb_show_scheduler;
  logic        clk;
  logic        rst_n;
  logic        run;
  logic        pl_we;
  logic [2:0]  pl_addr;
  logic [1:0]  pl_data;
  logic [3:0]  pl_len;
  logic [3:0]  pat_go;
  logic [3:0]  pat_finished;
  logic [31:0] pat_lights;
  logic [7:0]  lights;
  logic [1:0]  cur_pat;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [7:0] lit [4] = '{8'h3C, 8'h11, 8'hA5, 8'h7E};
  int seqv [8] = '{2, 3, 3, 1, 2, 1, 3, 0};
  int n;

  assign pat_lights = {lit[3], lit[2], lit[1], lit[0]};

  show_scheduler #(
    .NUM_PAT(4), .PL_DEPTH(8), .CLKS_PER_MS(4), .GAP_MS(2), .TIMEOUT_MS(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pl_we(pl_we), .pl_addr(pl_addr),
    .pl_data(pl_data), .pl_len(pl_len), .pat_go(pat_go), .pat_finished(pat_finished),
    .pat_lights(pat_lights), .lights(lights), .cur_pat(cur_pat), .busy(busy),
    .timeout_err(timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && pat_go != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_go: unexpected pat_go=%b with nothing expected", pat_go);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (pat_go !== e) begin
          failures++;
          $display("FAIL sb_go: pat_go=%b expected %b", pat_go, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [1:0] d);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic wait_go(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (pat_go == 4'b0000 && cnt < max);
  endtask

  // Finish the playing generator fin_k, expect a 9-cycle gap, then launch of next_k.
  task automatic step(input int fin_k, input int next_k);
    int c;
    exp_q.push_back(4'(1 << next_k));
    pat_finished = 4'(1 << fin_k);
    tick();
    pat_finished = 4'b0000;
    check("gap_lights", 32'(lights), 32'h0);
    wait_go(40, c);
    check("gap_len", 32'(c), 32'd9);
    tick();
    check("cur_pat", 32'(cur_pat), 32'(next_k));
    tick();
    check("play_lights", 32'(lights), 32'(lit[next_k]));
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    pl_len = '0; pat_finished = '0;
    tick(); tick();
    check("rst_lights", 32'(lights), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_go", 32'(pat_go), 32'h0);
    check("idle_cur_pat", 32'(cur_pat), 32'h0);
    check("idle_terr", 32'(timeout_err), 32'h0);

    write_entry(3'd0, 2'd2);
    write_entry(3'd1, 2'd0);
    write_entry(3'd2, 2'd3);
    pl_len = 4'd3;
    repeat (5) tick();
    check("idle_busy", 32'(busy), 32'h0);

    // basic play
    exp_q.push_back(4'b0100);
    run = 1'b1;
    wait_go(10, n);
    check("launch_lat", 32'(n), 32'd1);
    tick();
    check("play_cur_pat", 32'(cur_pat), 32'd2);
    check("play_busy", 32'(busy), 32'h1);
    tick();
    check("first_lights", 32'(lights), 32'hA5);
    pat_finished = 4'b0010;
    tick();
    pat_finished = 4'b0000;
    check("ignore_other_fin", 32'(lights), 32'hA5);
    step(2, 0);
    step(0, 3);
    step(3, 2);

    // live edits
    write_entry(3'd1, 2'd3);
    step(2, 3);
    step(3, 3);
    pl_len = 4'd1;
    step(3, 2);

    // watchdog
    check("terr_before", 32'(timeout_err), 32'h0);
    exp_q.push_back(4'b0100);
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout_err && n < 120);
    check("timeout_cycles", 32'(n), 32'd79);
    check("timeout_gap_lights", 32'(lights), 32'h0);
    wait_go(40, n);
    check("timeout_gap_len", 32'(n), 32'd9);
    tick(); tick();
    check("after_to_lights", 32'(lights), 32'hA5);
    check("terr_set", 32'(timeout_err), 32'h1);
    pl_len = 4'd3;
    step(2, 3);
    check("terr_sticky", 32'(timeout_err), 32'h1);

    // abort and restart
    run = 1'b0;
    tick();
    check("abort_lights", 32'(lights), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    tick(); tick();
    exp_q.push_back(4'b0100);
    run = 1'b1;
    wait_go(10, n);
    check("restart_lat", 32'(n), 32'd1);
    pat_finished = 4'b0100;
    tick();
    pat_finished = 4'b0000;
    tick();
    check("launch_fin_ignored", 32'(lights), 32'hA5);

    // pl_len=0 during gap ends in IDLE after the gap
    pat_finished = 4'b0100;
    tick();
    pat_finished = 4'b0000;
    pl_len = 4'd0;
    repeat (8) tick();
    check("gap_end_busy", 32'(busy), 32'h1);
    tick();
    check("len0_idle", 32'(busy), 32'h0);

    // pl_len=12 clamps to 8 entries
    write_entry(3'd3, 2'd1);
    write_entry(3'd4, 2'd2);
    write_entry(3'd5, 2'd1);
    write_entry(3'd6, 2'd3);
    write_entry(3'd7, 2'd0);
    exp_q.push_back(4'b0100);
    pl_len = 4'd12;
    wait_go(10, n);
    check("len12_lat", 32'(n), 32'd1);
    tick(); tick();
    check("len12_lights", 32'(lights), 32'hA5);
    for (int i = 1; i <= 8; i++) step(seqv[i-1], seqv[i % 8]);

    // reset during PLAY
    #1;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check("rst_play_lights", 32'(lights), 32'h0);
    check("rst_play_busy", 32'(busy), 32'h0);
    check("rst_play_cur_pat", 32'(cur_pat), 32'h0);
    check("rst_play_go", 32'(pat_go), 32'h0);
    tick();
    rst_n = 1'b1;
    pl_len = 4'd3;
    exp_q.push_back(4'b0001);
    run = 1'b1;
    wait_go(10, n);
    check("cleared_lat", 32'(n), 32'd1);
    tick();
    check("cleared_cur_pat", 32'(cur_pat), 32'h0);
    tick();
    check("cleared_lights", 32'(lights), 32'h3C);
    write_entry(3'd1, 2'd3);
    step(0, 3);

    // reset during GAP
    pat_finished = 4'b1000;
    tick();
    pat_finished = 4'b0000;
    tick(); tick();
    #1;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check("rst_gap_busy", 32'(busy), 32'h0);
    check("rst_gap_cur_pat", 32'(cur_pat), 32'h0);
    check("rst_gap_lights", 32'(lights), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // finish and timeout on the same cycle; run=0 during gap completes the gap
    exp_q.push_back(4'b0001);
    run = 1'b1;
    wait_go(10, n);
    check("coinc_lat", 32'(n), 32'd1);
    tick(); tick();
    repeat (78) tick();
    pat_finished = 4'b0001;
    tick();
    pat_finished = 4'b0000;
    check("coinc_terr", 32'(timeout_err), 32'h0);
    check("coinc_gap_lights", 32'(lights), 32'h0);
    repeat (2) tick();
    run = 1'b0;
    repeat (6) tick();
    check("gap_no_abort", 32'(busy), 32'h1);
    tick();
    check("gap_then_idle", 32'(busy), 32'h0);

    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/show_scheduler.md
Name: show_scheduler

Overview:
Sequences the light-pattern generators (go/finished, 8 light outputs each) through a programmable playlist and multiplexes the active generator onto the 8 physical light channels. It pulses one generator's go, forwards that generator's lights until it reports finished or a watchdog expires, blanks the lights for a gap, then advances. It sits between the pattern generators and the light drivers.

Parameters:
NUM_PAT, 4, number of pattern generators attached (2..8)
PL_DEPTH, 8, playlist entries (fixed 8; index width 3)
CLKS_PER_MS, 50000, clk cycles per millisecond tick
GAP_MS, 500, blackout duration between patterns, ms
TIMEOUT_MS, 600000, max ms a pattern may run before forced advance (must be < 2^20)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
run  in  1  level; 1 = play show, 0 = stop
pl_we  in  1  playlist write strobe
pl_addr  in  3  playlist entry to write
pl_data  in  clog2(NUM_PAT)  pattern index stored at pl_addr
pl_len  in  4  active playlist length; 0 = empty, >8 treated as 8
pat_go  out  NUM_PAT  one-hot start pulse to generator k
pat_finished  in  NUM_PAT  finished pulse from generator k
pat_lights  in  8*NUM_PAT  light outputs; generator k at bits [8k+7:8k]
lights  out  8  registered light outputs to drivers
cur_pat  out  clog2(NUM_PAT)  index of the generator being launched/played
busy  out  1  1 in any state except IDLE
timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset: state IDLE, playlist entries all 0, idx 0, lights 0, pat_go 0, cur_pat 0, busy 0, timeout_err 0, tick and ms counters 0.
- Tick: clk counter counts 0..CLKS_PER_MS-1 and produces a 1-cycle ms_tick at wrap. ms counter (20-bit) increments on ms_tick. Both counters clear on entry to LAUNCH and on entry to GAP.
- Playlist: a write while pl_we=1 updates entry[pl_addr] at the clock edge, in any state. The entry is latched into cur_pat only in LAUNCH, so writes never disturb the running pattern.
- FSM (states IDLE, LAUNCH, PLAY, GAP):
  - IDLE: lights 0. Go to LAUNCH when run=1 and pl_len!=0; idx stays at its current value (0 after reset or abort).
  - LAUNCH: exactly 1 cycle. cur_pat<=entry[idx]. pat_go[entry[idx]]=1 for this cycle only, decoded from the state register and the latched index. pat_finished is ignored in this cycle. Always go to PLAY.
  - PLAY: lights<=pat_lights[cur_pat slice] each cycle, so lights lag the generator by 1 clk.
    - pat_finished[cur_pat]=1: go to GAP and advance idx.
    - ms counter == TIMEOUT_MS: set timeout_err, go to GAP and advance idx.
    - Finished and timeout in the same cycle: finished wins; timeout_err is not set.
    - pat_finished from other generators is ignored.
    - run=0: abort to IDLE, idx<=0, lights<=0 on the next edge; no gap.
  - GAP: lights 0. When ms counter == GAP_MS:
    - run=1 and pl_len!=0: go to LAUNCH.
    - Otherwise: go to IDLE with idx<=0.
    - run=0 during GAP does not abort early; the gap completes first.
- idx advance: idx<=(idx+1 >= eff_len) ? 0 : idx+1, where eff_len = min(pl_len, 8) sampled at the advance cycle. If pl_len shrinks below the current idx, the next advance wraps to 0. If pl_len is 0 at the advance, the GAP-exit check sends the FSM to IDLE.
- No combinational path from pat_lights to lights. pat_go has no combinational dependence on inputs.

Test Plan:
(Bench parameters: CLKS_PER_MS=4, GAP_MS=2, TIMEOUT_MS=20, NUM_PAT=4.)
- Reset then idle: rst_n pulse, run=0 -> all outputs 0, busy=0 indefinitely; pl writes entry[0..2]=2,0,3, pl_len=3 while idle -> no pat_go.
- Basic play: entries 2,0,3, pl_len=3, run=1 -> pat_go=4'b0100 for exactly 1 cycle. Generator 2 drives 8'hA5 -> lights=8'hA5 one cycle later. Finished[2] pulse -> lights=0 for 8 clks (2 ms ±1 tick). Then pat_go=4'b0001; order 2,0,3,2,… wraps after idx 2.
- Watchdog: generator never finishes -> after 20 ms timeout_err=1, GAP, next entry launched. timeout_err stays 1 through later normal finishes. Finished and timeout on the same cycle -> timeout_err remains 0.
- Ignore and abort: pat_finished[1] while cur_pat=2 -> no transition. Finished in the LAUNCH cycle -> ignored. run=0 mid-PLAY -> next cycle lights=0, busy=0; run=1 -> restart from entry[0].
- Live edits: write entry[1]=3 during PLAY of entry[0] -> next launch uses 3. pl_len changed 3->1 while idx=2 -> wraps to 0. pl_len=0 during GAP -> IDLE after gap; pl_len=12 -> behaves as 8.
- Reset mid-operation: assert rst_n low during PLAY and during GAP -> all outputs 0 immediately (asynchronous), playlist cleared to 0.
